// File: rtl/regfile_pkg.sv
// Shared defaults for the scoreboarded register file: widths, register count
// and the pending-write counter type.
package regfile_pkg;

  localparam int XLEN_DEF  = 64;
  localparam int NREGS_DEF = 32;
  localparam int NRD_DEF   = 2;
  localparam int CNTW_DEF  = 2;
  localparam int AW_DEF    = $clog2(NREGS_DEF);

  typedef logic [CNTW_DEF-1:0] cnt_t;

  // Largest count a CNTW-bit pending-write counter can hold.
  function automatic int unsigned cnt_max(input int unsigned cntw);
    return (32'd1 << cntw) - 32'd1;
  endfunction

endpackage

// File: rtl/sb_counter.sv
// One pending-write counter: counts issued-but-unwritten producers of a
// register, saturating at its maximum; i_clr squashes pending counts.
module sb_counter
  import regfile_pkg::*;
#(
  parameter int CNTW = CNTW_DEF
) (
  input  logic i_clk,
  input  logic i_reset_n,
  input  logic i_clr,
  input  logic i_inc,
  input  logic i_dec,
  output logic o_busy,
  output logic o_sat,
  output logic o_one
);

  localparam logic [CNTW-1:0] MAX_CNT = CNTW'(cnt_max(CNTW));

  logic [CNTW-1:0] r_cnt;
  logic            w_inc;
  logic            w_dec;

  assign o_busy = (r_cnt != '0);
  assign o_sat  = (r_cnt == MAX_CNT);
  assign o_one  = (r_cnt == CNTW'(1));

  // A saturated counter ignores issues; a write only retires a tracked producer.
  assign w_inc = i_inc && !o_sat;
  assign w_dec = i_dec && o_busy && !i_clr;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= w_inc ? CNTW'(1) : '0;
    end else if (w_inc && !w_dec) begin
      r_cnt <= r_cnt + CNTW'(1);
    end else if (w_dec && !w_inc) begin
      r_cnt <= r_cnt - CNTW'(1);
    end
  end

endmodule

// File: rtl/regfile_sb.sv
// Register file with per-register pending-write scoreboard and busy flags.
// Define REGFILE_BYPASS_EN to forward same-cycle writeback data/busy to reads.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter  int XLEN  = XLEN_DEF,
  parameter  int NREGS = NREGS_DEF,
  parameter  int NRD   = NRD_DEF,
  parameter  int CNTW  = CNTW_DEF,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic [NRD*AW-1:0] i_rd_addr,
  output logic [NRD*XLEN-1:0] o_rd_data,
  output logic [NRD-1:0]    o_rd_busy,
  input  logic              i_issue_valid,
  input  logic [AW-1:0]     i_issue_rd,
  input  logic              i_we,
  input  logic [AW-1:0]     i_wr_addr,
  input  logic [XLEN-1:0]   i_wr_data,
  input  logic              i_flush,
  output logic              o_sb_err
);

  logic [XLEN-1:0]  r_mem [NREGS];
  logic [NREGS-1:0] w_busy;
  logic [NREGS-1:0] w_sat;
  logic [NREGS-1:0] w_one;
  logic             w_issue_sat;
  logic             r_sb_err;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      for (int i = 0; i < NREGS; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_we && (i_wr_addr != '0)) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  // Register 0 has no counter: it is never busy and can never saturate.
  assign w_busy[0] = 1'b0;
  assign w_sat[0]  = 1'b0;
  assign w_one[0]  = 1'b0;

  genvar gi;
  generate
    for (gi = 1; gi < NREGS; gi++) begin : g_cnt
      sb_counter #(.CNTW(CNTW)) u_cnt (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_clr     (i_flush),
        .i_inc     (i_issue_valid && (i_issue_rd == AW'(gi))),
        .i_dec     (i_we && (i_wr_addr == AW'(gi))),
        .o_busy    (w_busy[gi]),
        .o_sat     (w_sat[gi]),
        .o_one     (w_one[gi])
      );
    end
  endgenerate

  assign w_issue_sat = i_issue_valid && (i_issue_rd != '0) && w_sat[i_issue_rd];

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_sb_err <= 1'b0;
    end else if (w_issue_sat) begin
      r_sb_err <= 1'b1;
    end
  end

  assign o_sb_err = r_sb_err;

  generate
    for (gi = 0; gi < NRD; gi++) begin : g_rd
      logic [AW-1:0]   w_addr;
      logic [XLEN-1:0] w_stored;
      logic            w_hit;

      assign w_addr   = i_rd_addr[gi*AW +: AW];
      assign w_stored = (w_addr == '0) ? '0 : r_mem[w_addr];
      assign w_hit    = i_we && (i_wr_addr == w_addr) && (w_addr != '0);

`ifdef REGFILE_BYPASS_EN
      // The last outstanding producer writing this cycle clears busy early.
      assign o_rd_data[gi*XLEN +: XLEN] = w_hit ? i_wr_data : w_stored;
      assign o_rd_busy[gi] = w_busy[w_addr] && !(w_hit && w_one[w_addr]);
`else
      logic w_unused_hit;
      assign w_unused_hit = w_hit;
      assign o_rd_data[gi*XLEN +: XLEN] = w_stored;
      assign o_rd_busy[gi] = w_busy[w_addr];
`endif
    end
  endgenerate

`ifndef REGFILE_BYPASS_EN
  logic w_unused_one;
  assign w_unused_one = ^w_one;
`endif

endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench for regfile_sb: directed scenarios then random traffic,
// compared every cycle against an array/counter model of the scoreboard.
module tb_regfile_sb;

  localparam int XLEN  = 64;
  localparam int NREGS = 32;
  localparam int NRD   = 2;
  localparam int CNTW  = 2;
  localparam int AW    = 5;
  localparam int MAXC  = 3;

  logic                 clk;
  logic                 reset_n;
  logic [NRD*AW-1:0]    rd_addr;
  logic [NRD*XLEN-1:0]  rd_data;
  logic [NRD-1:0]       rd_busy;
  logic                 issue_valid;
  logic [AW-1:0]        issue_rd;
  logic                 we;
  logic [AW-1:0]        wr_addr;
  logic [XLEN-1:0]      wr_data;
  logic                 flush;
  logic                 sb_err;

  int total = 0;
  int bad   = 0;

  // Reference state
  logic [XLEN-1:0] m_mem [NREGS];
  int              m_cnt [NREGS];
  bit              m_err;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  regfile_sb #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .CNTW(CNTW)) dut (
    .i_clk         (clk),
    .i_reset_n     (reset_n),
    .i_rd_addr     (rd_addr),
    .o_rd_data     (rd_data),
    .o_rd_busy     (rd_busy),
    .i_issue_valid (issue_valid),
    .i_issue_rd    (issue_rd),
    .i_we          (we),
    .i_wr_addr     (wr_addr),
    .i_wr_data     (wr_data),
    .i_flush       (flush),
    .o_sb_err      (sb_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    for (int r = 0; r < NREGS; r++) begin
      m_mem[r] = '0;
      m_cnt[r] = 0;
    end
    m_err = 1'b0;
  endtask

  task automatic chk64(input string tag, input logic [XLEN-1:0] got, input logic [XLEN-1:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic got, input logic exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%b exp=%b", tag, got, exp);
    end
  endtask

  // Compare all outputs against the model for the inputs currently applied.
  task automatic check_all();
    logic [AW-1:0]   a;
    logic [XLEN-1:0] ed;
    logic            eb;
    bit              hit;
    for (int p = 0; p < NRD; p++) begin
      a   = rd_addr[p*AW +: AW];
      hit = BYPASS && we && (wr_addr == a) && (a != 0);
      ed  = (a == 0) ? '0 : (hit ? wr_data : m_mem[a]);
      eb  = (m_cnt[a] != 0) && !(hit && m_cnt[a] == 1);
      chk64($sformatf("rd_data%0d[r%0d]", p, a), rd_data[p*XLEN +: XLEN], ed);
      chk1($sformatf("rd_busy%0d[r%0d]", p, a), rd_busy[p], eb);
    end
    chk1("sb_err", sb_err, m_err);
  endtask

  // Apply the effect of the upcoming rising edge to the model.
  task automatic model_edge();
    bit inc, dec;
    if (issue_valid && issue_rd != 0 && m_cnt[issue_rd] == MAXC) m_err = 1'b1;
    for (int r = 1; r < NREGS; r++) begin
      inc = issue_valid && (issue_rd == r) && (m_cnt[r] < MAXC);
      dec = we && (wr_addr == r) && (m_cnt[r] > 0);
      if (flush) m_cnt[r] = inc ? 1 : 0;
      else m_cnt[r] = m_cnt[r] + int'(inc) - int'(dec);
    end
    if (we && wr_addr != 0) m_mem[wr_addr] = wr_data;
  endtask

  // One cycle: drive after the falling edge, check mid-cycle, then commit.
  task automatic step(input bit iv, input int ird, input bit w, input int wa,
                      input logic [XLEN-1:0] wd, input bit fl, input int a0, input int a1);
    @(negedge clk);
    issue_valid = iv;
    issue_rd    = AW'(ird);
    we          = w;
    wr_addr     = AW'(wa);
    wr_data     = wd;
    flush       = fl;
    rd_addr     = {AW'(a1), AW'(a0)};
    #1;
    check_all();
    $display("cyc iv=%0d ird=%0d we=%0d wa=%0d wd=%h fl=%0d a0=%0d a1=%0d -> d0=%h b0=%0d d1=%h b1=%0d err=%0d",
             iv, ird, w, wa, wd, fl, a0, a1, rd_data[XLEN-1:0], rd_busy[0],
             rd_data[2*XLEN-1:XLEN], rd_busy[1], sb_err);
    model_edge();
  endtask

  task automatic idle(input int a0, input int a1);
    step(0, 0, 0, 0, '0, 0, a0, a1);
  endtask

  initial begin
    reset_n     = 1'b0;
    issue_valid = 1'b0;
    issue_rd    = '0;
    we          = 1'b0;
    wr_addr     = '0;
    wr_data     = '0;
    flush       = 1'b0;
    rd_addr     = '0;
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    chk1("reset_busy0", rd_busy[0], 1'b0);
    chk1("reset_err", sb_err, 1'b0);
    reset_n = 1'b1;

    // Reset contents: every register reads zero, nothing busy
    for (int k = 0; k < NREGS; k += 2) idle(k, k + 1);

    // Write r5 then read it back
    step(0, 0, 1, 5, 64'h1234, 0, 5, 0);
    idle(5, 5);
    chk64("r5_readback", rd_data[XLEN-1:0], 64'h1234);

    // Single producer on r7
    step(1, 7, 0, 0, '0, 0, 7, 0);
    idle(7, 0);
    chk1("r7_busy", rd_busy[0], 1'b1);
    step(0, 0, 1, 7, 64'hAA, 0, 7, 7);
    idle(7, 7);
    chk1("r7_released", rd_busy[0], 1'b0);

    // Saturate r3, then retire three writes
    for (int k = 0; k < 4; k++) step(1, 3, 0, 0, '0, 0, 3, 0);
    idle(3, 0);
    chk1("sat_err", sb_err, 1'b1);
    for (int k = 0; k < 3; k++) step(0, 0, 1, 3, 64'(k + 16), 0, 3, 3);
    idle(3, 3);

    // Same-cycle issue and write of r9 with one pending; r0 write discarded
    step(1, 9, 0, 0, '0, 0, 9, 0);
    step(1, 9, 1, 9, 64'h99, 0, 9, 0);
    idle(9, 0);
    chk1("r9_still_busy", rd_busy[0], 1'b1);
    step(0, 0, 1, 0, 64'hFF, 0, 0, 9);
    idle(0, 0);

    // Flush with a simultaneous issue of r8
    step(1, 4, 0, 0, '0, 0, 4, 6);
    step(1, 6, 0, 0, '0, 0, 4, 6);
    step(1, 8, 0, 0, '0, 1, 4, 6);
    idle(4, 8);
    idle(6, 8);
    chk1("r8_after_flush", rd_busy[1], 1'b1);

    // Randomized traffic over a small register window to force hazards
    for (int k = 0; k < 400; k++) begin
      step($urandom_range(0, 1), $urandom_range(0, 7), $urandom_range(0, 1),
           $urandom_range(0, 7), {$urandom, $urandom}, ($urandom_range(0, 15) == 0),
           $urandom_range(0, 7), $urandom_range(0, 7));
    end

    // Asynchronous reset mid-stream
    step(1, 2, 1, 2, 64'h5555, 0, 2, 3);
    @(negedge clk);
    issue_valid = 1'b0;
    we          = 1'b0;
    flush       = 1'b0;
    rd_addr     = {AW'(2), AW'(3)};
    #2;
    reset_n = 1'b0;
    #1;
    model_reset();
    check_all();
    @(negedge clk);
    reset_n = 1'b1;
    idle(2, 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    bad++;
    $display("FAIL timeout total=%0d", total);
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

endmodule
